// File: rtl/wb_trace_uart.sv
// ---------------------------------------------------------------------------
// wb_trace_uart
// Debug trace tap on the writeback stage. Every architectural register write
// (rd != x0) is pushed into a small FIFO and then sent out as a 6-byte UART
// 8N1 frame: 0xA5, {3'b000,rd}, data[31:24], data[23:16], data[15:8],
// data[7:0]. The core is never stalled: events arriving while the FIFO is full
// are dropped and the sticky overflow flag is raised.
//
// Ports
//   clk            system clock, all state on the rising edge
//   resetn         asynchronous active-low reset (aborts a frame in flight)
//   enable         1 = capture writeback events, 0 = ignore new events
//   wb_valid       writeback register-write enable
//   wb_rd          writeback destination register
//   wb_data        writeback data
//   clear_overflow synchronous clear of the overflow flag
//   uart_tx        UART serial output, idle high, driven from a flop
//   busy           high while a frame is being transmitted
//   fifo_level     FIFO occupancy, 0 .. 2**FIFO_AW
//   fifo_full      fifo_level == 2**FIFO_AW
//   overflow       sticky: at least one event was dropped
// ---------------------------------------------------------------------------
module wb_trace_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic [31:0]        wb_data,
    input  logic               clear_overflow,
    output logic               uart_tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               fifo_full,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]   CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   LEVEL_EMPTY = (FIFO_AW + 1)'(0);
    localparam logic [FIFO_AW:0]   LEVEL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ZERO    = FIFO_AW'(0);
    localparam logic [FIFO_AW-1:0] PTR_ONE     = FIFO_AW'(1);
    localparam logic [7:0]         SYNC_BYTE   = 8'hA5;
    localparam logic [2:0]         LAST_BIT    = 3'd7;
    localparam logic [2:0]         LAST_BYTE   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Selects byte idx (0..5) of the frame for a latched {rd,data} entry.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [36:0] entry);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {3'b000, entry[36:32]};
            3'd2:    b = entry[31:24];
            3'd3:    b = entry[23:16];
            3'd4:    b = entry[15:8];
            3'd5:    b = entry[7:0];
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

    // FIFO storage and bookkeeping
    logic [36:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               overflow_r;

    logic               fifo_full_s;
    logic               event_s;
    logic               push_s;
    logic               drop_s;
    logic               pop_s;
    logic [36:0]        head_s;

    // Transmitter state
    state_t             state_r,    state_nx_s;
    logic [CNT_W-1:0]   baud_cnt_r, baud_cnt_nx_s;
    logic [2:0]         bit_idx_r,  bit_idx_nx_s;
    logic [2:0]         byte_idx_r, byte_idx_nx_s;
    logic [7:0]         shift_r,    shift_nx_s;
    logic [36:0]        entry_r,    entry_nx_s;
    logic               tx_r,       tx_nx_s;
    logic               busy_r,     busy_nx_s;
    logic               baud_last_s;

    assign fifo_full_s = (level_r == LEVEL_FULL);
    assign event_s     = enable & wb_valid & (wb_rd != 5'd0);
    // A full FIFO drops the event even if the transmitter pops on the same
    // edge: fullness is judged on the value before the edge.
    assign push_s      = event_s & ~fifo_full_s;
    assign drop_s      = event_s & fifo_full_s;
    assign pop_s       = (state_r == ST_IDLE) && (level_r != LEVEL_EMPTY);
    assign head_s      = mem_r[rd_ptr_r];
    assign baud_last_s = (baud_cnt_r == CNT_LAST);

    assign uart_tx    = tx_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;
    assign fifo_full  = fifo_full_s;
    assign overflow   = overflow_r;

    // FIFO payload write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {wb_rd, wb_data};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LEVEL_EMPTY;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
            // A drop in the same cycle beats a clear request.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Transmitter state register; uart_tx and busy come straight from flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 3'd0;
            shift_r    <= 8'h00;
            entry_r    <= 37'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            baud_cnt_r <= baud_cnt_nx_s;
            bit_idx_r  <= bit_idx_nx_s;
            byte_idx_r <= byte_idx_nx_s;
            shift_r    <= shift_nx_s;
            entry_r    <= entry_nx_s;
            tx_r       <= tx_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    // Transmitter next-state logic: one start bit, 8 data bits LSB first, one
    // stop bit per byte; bytes of a frame follow each other with no gap.
    always_comb begin
        state_nx_s    = state_r;
        baud_cnt_nx_s = baud_cnt_r;
        bit_idx_nx_s  = bit_idx_r;
        byte_idx_nx_s = byte_idx_r;
        shift_nx_s    = shift_r;
        entry_nx_s    = entry_r;
        tx_nx_s       = tx_r;
        busy_nx_s     = busy_r;

        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    entry_nx_s    = head_s;
                    byte_idx_nx_s = 3'd0;
                    shift_nx_s    = SYNC_BYTE;
                    baud_cnt_nx_s = CNT_ZERO;
                    tx_nx_s       = 1'b0;
                    busy_nx_s     = 1'b1;
                    state_nx_s    = ST_START;
                end else begin
                    tx_nx_s   = 1'b1;
                    busy_nx_s = 1'b0;
                end
            end

            ST_START: begin
                if (baud_last_s) begin
                    baud_cnt_nx_s = CNT_ZERO;
                    bit_idx_nx_s  = 3'd0;
                    tx_nx_s       = shift_r[0];
                    state_nx_s    = ST_DATA;
                end else begin
                    baud_cnt_nx_s = baud_cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (baud_last_s) begin
                    baud_cnt_nx_s = CNT_ZERO;
                    if (bit_idx_r == LAST_BIT) begin
                        tx_nx_s    = 1'b1;
                        state_nx_s = ST_STOP;
                    end else begin
                        // shift_r[0] is on the line; shift_r[1] goes next.
                        bit_idx_nx_s = bit_idx_r + 3'd1;
                        shift_nx_s   = {1'b0, shift_r[7:1]};
                        tx_nx_s      = shift_r[1];
                    end
                end else begin
                    baud_cnt_nx_s = baud_cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (baud_last_s) begin
                    baud_cnt_nx_s = CNT_ZERO;
                    if (byte_idx_r == LAST_BYTE) begin
                        tx_nx_s    = 1'b1;
                        busy_nx_s  = 1'b0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        byte_idx_nx_s = byte_idx_r + 3'd1;
                        shift_nx_s    = frame_byte(byte_idx_r + 3'd1, entry_r);
                        tx_nx_s       = 1'b0;
                        state_nx_s    = ST_START;
                    end
                end else begin
                    baud_cnt_nx_s = baud_cnt_r + CNT_ONE;
                end
            end

            default: begin
                baud_cnt_nx_s = CNT_ZERO;
                tx_nx_s       = 1'b1;
                busy_nx_s     = 1'b0;
                state_nx_s    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_trace_uart.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_uart
// Directed self-checking bench for wb_trace_uart with CLKS_PER_BIT=4 and
// FIFO_AW=2 (4-entry FIFO). Inputs change and outputs are sampled 1 ns after
// each rising clock edge. The UART line is checked bit-by-bit against the
// expected 8N1 pattern for every byte of every frame.
// ---------------------------------------------------------------------------
module tb_wb_trace_uart;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          clear_overflow;
    logic          uart_tx;
    logic          busy;
    logic [AW:0]   fifo_level;
    logic          fifo_full;
    logic          overflow;

    int total;
    int bad;

    wb_trace_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .clear_overflow(clear_overflow),
        .uart_tx       (uart_tx),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Checks one 8N1 byte, starting skip cycles into its start bit.
    task automatic rx_byte(input string tag, input logic [7:0] exp_b, input int skip);
        logic [9:0] pat;
        logic [7:0] got;
        int         errs;
        pat  = {1'b1, exp_b, 1'b0};
        got  = 8'h00;
        errs = 0;
        for (int k = skip; k < 10 * CPB; k++) begin
            if (uart_tx !== pat[k / CPB]) errs++;
            if (busy !== 1'b1) errs++;
            if ((k % CPB) == (CPB / 2) && (k / CPB) >= 1 && (k / CPB) <= 8)
                got[(k / CPB) - 1] = uart_tx;
            tick();
        end
        chk($sformatf("%s_byte", tag), {56'd0, got}, {56'd0, exp_b});
        chk($sformatf("%s_timing", tag), 64'(errs), 64'd0);
    endtask

    task automatic rx_frame(input string tag, input logic [4:0] rd, input logic [31:0] data,
                            input int skip);
        logic [7:0] b [6];
        b[0] = 8'hA5;
        b[1] = {3'b000, rd};
        b[2] = data[31:24];
        b[3] = data[23:16];
        b[4] = data[15:8];
        b[5] = data[7:0];
        for (int i = 0; i < 6; i++)
            rx_byte($sformatf("%s_b%0d", tag, i), b[i], (i == 0) ? skip : 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (busy === 1'b0 && fifo_level === 3'd0 && uart_tx === 1'b1) done = 1'b1;
            else tick();
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    initial begin
        int errs;
        total = 0;
        bad = 0;
        resetn = 1'b0;
        enable = 1'b1;
        wb_valid = 1'b0;
        wb_rd = 5'd0;
        wb_data = 32'd0;
        clear_overflow = 1'b0;

        // Reset state
        #12;
        chk("rst_tx", {63'd0, uart_tx}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_level", {61'd0, fifo_level}, 64'd0);
        chk("rst_full", {63'd0, fifo_full}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();

        // T1: single event, 1-cycle latency, 240-cycle frame
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_valid = 1'b0;
        chk("t1_level_push", {61'd0, fifo_level}, 64'd1);
        chk("t1_tx_before", {63'd0, uart_tx}, 64'd1);
        tick();
        chk("t1_tx_start", {63'd0, uart_tx}, 64'd0);
        chk("t1_busy_start", {63'd0, busy}, 64'd1);
        chk("t1_level_pop", {61'd0, fifo_level}, 64'd0);
        rx_frame("t1", 5'd5, 32'hDEADBEEF, 0);
        chk("t1_tx_end", {63'd0, uart_tx}, 64'd1);
        chk("t1_busy_end", {63'd0, busy}, 64'd0);

        // T2: x0 writes and disabled capture are ignored
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h11111111;
        tick();
        enable = 1'b0; wb_rd = 5'd3;
        tick();
        wb_valid = 1'b0; enable = 1'b1;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_level !== 3'd0 || uart_tx !== 1'b1 || busy !== 1'b0) errs++;
            tick();
        end
        chk("t2_ignored", 64'(errs), 64'd0);

        // T3: six consecutive events into a 4-deep FIFO, rd=6 dropped
        for (int i = 1; i <= 6; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'(i);
            tick();
            if (i == 2) chk("t3_level_e2", {61'd0, fifo_level}, 64'd1);
            if (i == 4) chk("t3_full_e4", {63'd0, fifo_full}, 64'd0);
            if (i == 5) chk("t3_ovf_e5", {63'd0, overflow}, 64'd0);
        end
        wb_valid = 1'b0;
        chk("t3_full_e6", {63'd0, fifo_full}, 64'd1);
        chk("t3_level_e6", {61'd0, fifo_level}, 64'd4);
        chk("t3_ovf_e6", {63'd0, overflow}, 64'd1);
        for (int i = 1; i <= 5; i++) begin
            rx_frame($sformatf("t3_f%0d", i), 5'(i), 32'(i), (i == 1) ? 4 : 0);
            chk($sformatf("t3_gap%0d", i), {63'd0, uart_tx}, 64'd1);
            chk($sformatf("t3_gapbusy%0d", i), {63'd0, busy}, 64'd0);
            if (i < 5) tick();
        end
        chk("t3_level_end", {61'd0, fifo_level}, 64'd0);
        tick();
        chk("t3_ovf_hold", {63'd0, overflow}, 64'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t3_ovf_clear", {63'd0, overflow}, 64'd0);

        // T4: drop and clear_overflow in the same cycle -> set wins
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(9 + i); wb_data = 32'(i);
            tick();
        end
        chk("t4_full", {63'd0, fifo_full}, 64'd1);
        chk("t4_ovf_before", {63'd0, overflow}, 64'd0);
        wb_rd = 5'd14; clear_overflow = 1'b1;
        tick();
        wb_valid = 1'b0; clear_overflow = 1'b0;
        chk("t4_ovf_set_wins", {63'd0, overflow}, 64'd1);
        chk("t4_level", {61'd0, fifo_level}, 64'd4);
        wait_idle("t4_drain", 5 * 60 * CPB + 50);

        // T5: back-to-back frames, one idle cycle between them
        tick();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h00000001;
        tick();
        wb_valid = 1'b0;
        chk("t5_level_a", {61'd0, fifo_level}, 64'd1);
        tick();
        chk("t5_level_b", {61'd0, fifo_level}, 64'd0);
        chk("t5_tx_start", {63'd0, uart_tx}, 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h80000000;
        tick();
        wb_valid = 1'b0;
        chk("t5_level_c", {61'd0, fifo_level}, 64'd1);
        rx_frame("t5_f1", 5'd7, 32'h00000001, 1);
        chk("t5_gap_tx", {63'd0, uart_tx}, 64'd1);
        chk("t5_gap_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("t5_level_d", {61'd0, fifo_level}, 64'd0);
        rx_frame("t5_f2", 5'd8, 32'h80000000, 0);
        chk("t5_idle_tx", {63'd0, uart_tx}, 64'd1);
        chk("t5_idle_busy", {63'd0, busy}, 64'd0);

        // T6: asynchronous reset during data bits of byte 2
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h12345678;
        tick();
        wb_valid = 1'b0;
        tick();
        rx_byte("t6_b0", 8'hA5, 0);
        rx_byte("t6_b1", 8'h09, 0);
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hCAFEF00D;
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_tx_bit0", {63'd0, uart_tx}, 64'd0);
        chk("t6_level_pre", {61'd0, fifo_level}, 64'd1);
        chk("t6_ovf_pre", {63'd0, overflow}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_tx_async", {63'd0, uart_tx}, 64'd1);
        chk("t6_busy_async", {63'd0, busy}, 64'd0);
        chk("t6_level_async", {61'd0, fifo_level}, 64'd0);
        chk("t6_ovf_async", {63'd0, overflow}, 64'd0);
        tick();
        resetn = 1'b1;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) errs++;
            tick();
        end
        chk("t6_quiet", 64'(errs), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
